// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmit scheduler and framer.
// Frames are start/data/(parity)/stop; one bit advances per shared baud tick.
module uart_tx_sched #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    output logic                 baud_clr,
    input  logic                 req0,
    input  logic [DATA_BITS-1:0] data0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [DATA_BITS-1:0] data1,
    output logic                 ack1,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic                 grant_id
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [2:0] LAST_IDX   = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
    localparam logic       ODD        = (PARITY_ODD != 0);
    localparam bit         HAS_PARITY = (PARITY_EN != 0);

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [2:0]           idx, idx_nxt;
    logic                 stop_cnt, stop_cnt_nxt;
    logic                 parity_bit, parity_nxt;
    logic                 prio, prio_nxt;
    logic                 grant_nxt;
    logic                 ack0_nxt, ack1_nxt, done_nxt;
    logic                 tx_nxt;
    logic                 win1;
    logic [DATA_BITS-1:0] win_data;

    // prio=1 means requester 1 wins a tie; it always points away from the last winner
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        idx_nxt      = idx;
        stop_cnt_nxt = stop_cnt;
        parity_nxt   = parity_bit;
        prio_nxt     = prio;
        grant_nxt    = grant_id;
        ack0_nxt     = 1'b0;
        ack1_nxt     = 1'b0;
        done_nxt     = 1'b0;
        win1         = req1 & (~req0 | prio);
        win_data     = win1 ? data1 : data0;

        unique case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_nxt  = START;
                    grant_nxt  = win1;
                    prio_nxt   = ~win1;
                    ack0_nxt   = ~win1;
                    ack1_nxt   = win1;
                    shreg_nxt  = win_data;
                    parity_nxt = (^win_data) ^ ODD;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_nxt = DATA;
                    idx_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shreg_nxt = shreg >> 1;
                    idx_nxt   = idx + 3'd1;
                    if (idx == LAST_IDX) begin
                        state_nxt    = HAS_PARITY ? PARITY : STOP;
                        stop_cnt_nxt = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_nxt    = STOP;
                    stop_cnt_nxt = 1'b0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        stop_cnt_nxt = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // outputs are registered, so they are decoded from the state being entered
        unique case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            PARITY:  tx_nxt = parity_nxt;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= 3'd0;
            stop_cnt <= 1'b0;
            prio     <= 1'b0;
            grant_id <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            done     <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_clr <= 1'b1;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            stop_cnt <= stop_cnt_nxt;
            prio     <= prio_nxt;
            grant_id <= grant_nxt;
            ack0     <= ack0_nxt;
            ack1     <= ack1_nxt;
            done     <= done_nxt;
            tx       <= tx_nxt;
            busy     <= (state_nxt != IDLE);
            baud_clr <= (state_nxt == IDLE);
        end
    end

    // Datapath needs no reset: it is only observed after a fresh grant reloads it
    always_ff @(posedge clk) begin
        shreg      <= shreg_nxt;
        parity_bit <= parity_nxt;
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: an 8N1 instance and an 8-odd-parity-2-stop instance,
// each fed by a modelled baud generator, checked against a frame-level reference.
module tb_uart_tx_sched;

    localparam int DIV = 10;

    typedef struct {
        logic [15:0] bits;
        int          len;
        logic        src;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic force_tick;
    logic d0_req0, d0_req1, d1_req0, d1_req1;
    logic [7:0] d0_data0, d0_data1, d1_data0, d1_data1;
    logic d0_tick, d0_clr, d0_ack0, d0_ack1, d0_tx, d0_busy, d0_done, d0_gid;
    logic d1_tick, d1_clr, d1_ack0, d1_ack1, d1_tx, d1_busy, d1_done, d1_gid;
    int   cnt0, cnt1;

    int checks = 0;
    int passed = 0;

    frame_t mon0_q[$], mon1_q[$], exp0_q[$], exp1_q[$];
    logic   ack0_q[$], ack1_q[$];
    int     ack_err0 = 0, ack_err1 = 0;
    logic   prev_ack0 = 1'b0, prev_ack1 = 1'b0;
    logic   mprio [2];
    logic [15:0] cur_bits0, cur_bits1;
    int     cur_len0, cur_len1;

    uart_tx_sched #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .baud_tick(d0_tick), .baud_clr(d0_clr),
        .req0(d0_req0), .data0(d0_data0), .ack0(d0_ack0),
        .req1(d0_req1), .data1(d0_data1), .ack1(d0_ack1),
        .tx(d0_tx), .busy(d0_busy), .done(d0_done), .grant_id(d0_gid));

    uart_tx_sched #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
        .clk(clk), .reset(reset), .baud_tick(d1_tick), .baud_clr(d1_clr),
        .req0(d1_req0), .data0(d1_data0), .ack0(d1_ack0),
        .req1(d1_req1), .data1(d1_data1), .ack1(d1_ack1),
        .tx(d1_tx), .busy(d1_busy), .done(d1_done), .grant_id(d1_gid));

    // Baud generators: held at zero while cleared, tick on the DIV-th cycle after
    always @(posedge clk or negedge reset) begin
        if (!reset) cnt0 <= 0;
        else if (d0_clr || cnt0 == DIV - 1) cnt0 <= 0;
        else cnt0 <= cnt0 + 1;
    end
    always @(posedge clk or negedge reset) begin
        if (!reset) cnt1 <= 0;
        else if (d1_clr || cnt1 == DIV - 1) cnt1 <= 0;
        else cnt1 <= cnt1 + 1;
    end
    assign d0_tick = (cnt0 == DIV - 1) || force_tick;
    assign d1_tick = (cnt1 == DIV - 1) || force_tick;

    // Line monitors: sample tx on every tick of a busy frame, close the frame on done
    always @(negedge clk) begin
        frame_t f;
        if (!reset) begin
            cur_bits0 = '0; cur_len0 = 0; prev_ack0 = 1'b0;
        end else begin
            if (d0_tick && d0_busy && cur_len0 < 16) begin
                cur_bits0[cur_len0] = d0_tx; cur_len0++;
            end
            if (d0_done) begin
                f.bits = cur_bits0; f.len = cur_len0; f.src = d0_gid;
                mon0_q.push_back(f); cur_bits0 = '0; cur_len0 = 0;
            end
            if (d0_ack0) ack0_q.push_back(1'b0);
            if (d0_ack1) ack0_q.push_back(1'b1);
            if ((d0_ack0 && d0_ack1) || ((d0_ack0 || d0_ack1) && prev_ack0)) ack_err0++;
            prev_ack0 = d0_ack0 || d0_ack1;
        end
    end
    always @(negedge clk) begin
        frame_t f;
        if (!reset) begin
            cur_bits1 = '0; cur_len1 = 0; prev_ack1 = 1'b0;
        end else begin
            if (d1_tick && d1_busy && cur_len1 < 16) begin
                cur_bits1[cur_len1] = d1_tx; cur_len1++;
            end
            if (d1_done) begin
                f.bits = cur_bits1; f.len = cur_len1; f.src = d1_gid;
                mon1_q.push_back(f); cur_bits1 = '0; cur_len1 = 0;
            end
            if (d1_ack0) ack1_q.push_back(1'b0);
            if (d1_ack1) ack1_q.push_back(1'b1);
            if ((d1_ack0 && d1_ack1) || ((d1_ack0 || d1_ack1) && prev_ack1)) ack_err1++;
            prev_ack1 = d1_ack0 || d1_ack1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop ones
    function automatic frame_t model_frame(input int which, input logic [7:0] d, input logic src);
        frame_t f;
        int n = 0;
        int ones = 0;
        int stops = (which == 0) ? 1 : 2;
        f.bits = '0;
        f.bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            f.bits[n] = d[i]; ones += int'(d[i]); n++;
        end
        if (which == 1) begin
            f.bits[n] = ((ones % 2) == 1) ^ 1'b1; n++;
        end
        for (int i = 0; i < stops; i++) begin
            f.bits[n] = 1'b1; n++;
        end
        f.len = n; f.src = src;
        return f;
    endfunction

    task automatic push_exp(input int which, input frame_t f);
        if (which == 0) exp0_q.push_back(f); else exp1_q.push_back(f);
    endtask

    // pat bit0 = requester 0 asks, bit1 = requester 1 asks; mprio is the next tie winner
    task automatic predict(input int which, input int pat, input logic [7:0] a, input logic [7:0] b);
        if (pat == 1) begin
            push_exp(which, model_frame(which, a, 1'b0)); mprio[which] = 1'b1;
        end else if (pat == 2) begin
            push_exp(which, model_frame(which, b, 1'b1)); mprio[which] = 1'b0;
        end else if (mprio[which] == 1'b0) begin
            push_exp(which, model_frame(which, a, 1'b0));
            push_exp(which, model_frame(which, b, 1'b1));
        end else begin
            push_exp(which, model_frame(which, b, 1'b1));
            push_exp(which, model_frame(which, a, 1'b0));
        end
    endtask

    task automatic drive(input int which, input int pat, input logic [7:0] a, input logic [7:0] b);
        if (which == 0) begin
            d0_data0 = a; d0_data1 = b; d0_req0 = pat[0]; d0_req1 = pat[1];
        end else begin
            d1_data0 = a; d1_data1 = b; d1_req0 = pat[0]; d1_req1 = pat[1];
        end
    endtask

    // Requesters drop req on their ack; wait for n done pulses within a cycle budget
    task automatic run_frames(input int which, input int n, input int budget);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk); cyc++;
            if (which == 0) begin
                if (d0_ack0) d0_req0 = 1'b0;
                if (d0_ack1) d0_req1 = 1'b0;
                if (d0_done) seen++;
            end else begin
                if (d1_ack0) d1_req0 = 1'b0;
                if (d1_ack1) d1_req1 = 1'b0;
                if (d1_done) seen++;
            end
        end
        check($sformatf("done_count_dut%0d", which), seen, n);
        #1;
    endtask

    task automatic compare_frames(input int which, input int n, input string tag);
        frame_t e, m;
        logic a;
        check($sformatf("%s_mon_cnt", tag), (which == 0) ? mon0_q.size() : mon1_q.size(), n);
        check($sformatf("%s_ack_cnt", tag), (which == 0) ? ack0_q.size() : ack1_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) begin
                if (mon0_q.size() == 0 || ack0_q.size() == 0 || exp0_q.size() == 0) break;
                e = exp0_q.pop_front(); m = mon0_q.pop_front(); a = ack0_q.pop_front();
            end else begin
                if (mon1_q.size() == 0 || ack1_q.size() == 0 || exp1_q.size() == 0) break;
                e = exp1_q.pop_front(); m = mon1_q.pop_front(); a = ack1_q.pop_front();
            end
            check($sformatf("%s_%0d_bits", tag, i), m.bits, e.bits);
            check($sformatf("%s_%0d_len", tag, i), m.len, e.len);
            check($sformatf("%s_%0d_grant", tag, i), m.src, e.src);
            check($sformatf("%s_%0d_ack", tag, i), a, e.src);
        end
    endtask

    initial begin
        int dn, cyc, last_done, nt, pat;
        logic [7:0] a, b;
        frame_t f;

        reset = 1'b0; force_tick = 1'b0;
        drive(0, 0, 8'h00, 8'h00); drive(1, 0, 8'h00, 8'h00);
        mprio[0] = 1'b0; mprio[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs_dut0", {d0_tx, d0_clr, d0_ack0, d0_ack1, d0_busy, d0_done, d0_gid}, 7'b1100000);
        check("rst_outs_dut1", {d1_tx, d1_clr, d1_ack0, d1_ack1, d1_busy, d1_done, d1_gid}, 7'b1100000);
        reset = 1'b1;
        @(negedge clk);

        // Stray ticks while idle change nothing
        for (int k = 0; k < 3; k++) begin
            force_tick = 1'b1;
            @(negedge clk);
            force_tick = 1'b0;
            check("idle_tick_dut0", {d0_tx, d0_clr, d0_ack0, d0_ack1, d0_busy, d0_done}, 6'b110000);
            check("idle_tick_dut1", {d1_tx, d1_clr, d1_ack0, d1_ack1, d1_busy, d1_done}, 6'b110000);
        end

        // Both requesters held: frames alternate, requester 0 first
        for (int i = 0; i < 3; i++) begin
            f = model_frame(0, mprio[0] ? 8'h22 : 8'h11, mprio[0]);
            exp0_q.push_back(f);
            mprio[0] = ~mprio[0];
        end
        drive(0, 3, 8'h11, 8'h22);
        dn = 0; cyc = 0; last_done = -10;
        while (dn < 3 && cyc < 1000) begin
            @(negedge clk); cyc++;
            if ((d0_ack0 || d0_ack1) && dn > 0) check("ack_after_done", cyc - last_done, 1);
            if (d0_done) begin dn++; last_done = cyc; end
        end
        drive(0, 0, 8'h11, 8'h22);
        check("held_dones", dn, 3);
        #1;
        if (mon0_q.size() > 0) check("held_first_src", mon0_q[0].src, 1'b0);
        compare_frames(0, 3, "held");

        // Single request, 0xA5 on 8N1
        drive(0, 1, 8'hA5, 8'h00);
        predict(0, 1, 8'hA5, 8'h00);
        @(negedge clk);
        check("first_ack", {d0_ack0, d0_ack1, d0_tx, d0_clr, d0_busy, d0_gid}, 6'b100010);
        d0_req0 = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", {d0_ack0, d0_ack1}, 2'b00);
        run_frames(0, 1, 300);
        if (mon0_q.size() > 0) check("a5_line", mon0_q[0].bits, 16'h034A);
        compare_frames(0, 1, "a5");

        // Odd parity with two stop bits
        drive(1, 1, 8'h07, 8'h00);
        predict(1, 1, 8'h07, 8'h00);
        run_frames(1, 1, 400);
        if (mon1_q.size() > 0) check("p07_line", mon1_q[0].bits, 16'h0C0E);
        compare_frames(1, 1, "p07");
        drive(1, 2, 8'h00, 8'hFF);
        predict(1, 2, 8'h00, 8'hFF);
        run_frames(1, 1, 400);
        if (mon1_q.size() > 0) check("pff_line", mon1_q[0].bits, 16'h0FFE);
        compare_frames(1, 1, "pff");

        // Reset during data bit 3 aborts the frame immediately
        drive(0, 1, 8'hC3, 8'h00);
        nt = 0; cyc = 0;
        while (nt < 4 && cyc < 300) begin
            @(negedge clk); cyc++;
            if (d0_ack0) d0_req0 = 1'b0;
            if (d0_tick && d0_busy) nt++;
        end
        check("reach_bit3", nt, 4);
        repeat (3) @(negedge clk);
        check("bit3_line", {d0_tx, d0_busy, d0_clr}, 3'b010);
        #2 reset = 1'b0;
        #1 check("async_abort", {d0_tx, d0_busy, d0_clr, d0_done}, 4'b1010);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mprio[0] = 1'b0; mprio[1] = 1'b0;
        mon0_q.delete(); ack0_q.delete();
        check("abort_no_frame_pending", exp0_q.size(), 0);

        // Tie after reset goes to requester 0 again
        drive(0, 3, 8'h5A, 8'h3C);
        predict(0, 3, 8'h5A, 8'h3C);
        run_frames(0, 2, 500);
        compare_frames(0, 2, "post_rst");

        // Random request patterns on both configurations
        for (int w = 0; w < 2; w++) begin
            for (int t = 0; t < 8; t++) begin
                pat = int'($urandom_range(1, 3));
                a = 8'($urandom); b = 8'($urandom);
                predict(w, pat, a, b);
                drive(w, pat, a, b);
                run_frames(w, (pat == 3) ? 2 : 1, 600);
                compare_frames(w, (pat == 3) ? 2 : 1, $sformatf("rnd%0d_%0d", w, t));
            end
        end

        check("ack_pulse_err_dut0", ack_err0, 0);
        check("ack_pulse_err_dut1", ack_err1, 0);
        check("leftover_dut0", mon0_q.size() + exp0_q.size(), 0);
        check("leftover_dut1", mon1_q.size() + exp1_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
